// File: rtl/cpu_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: FSM states, the
// register-stage latch layout, and the opcode/funct constants used by decode.
package cpu_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ST_W = 3;

  localparam logic [ST_W-1:0] ST_RST    = 3'd0;
  localparam logic [ST_W-1:0] ST_FETCH  = 3'd1;
  localparam logic [ST_W-1:0] ST_DECODE = 3'd2;
  localparam logic [ST_W-1:0] ST_EXEC   = 3'd3;
  localparam logic [ST_W-1:0] ST_MEM    = 3'd4;
  localparam logic [ST_W-1:0] ST_WB     = 3'd5;
  localparam logic [ST_W-1:0] ST_HALT   = 3'd7;

  localparam logic [XLEN-1:0] NOP_INS = 32'h0000_0000;

  // Opcode and funct fields shared with decode
  localparam logic [5:0] EXE_SPECIAL = 6'b000000;
  localparam logic [5:0] EXE_J       = 6'b000010;
  localparam logic [5:0] EXE_BEQ     = 6'b000100;
  localparam logic [5:0] EXE_LW      = 6'b100011;
  localparam logic [5:0] EXE_SW      = 6'b101011;
  localparam logic [5:0] EXE_ADDU    = 6'b100001;
  localparam logic [5:0] EXE_SUBU    = 6'b100011;

  // Decode results captured in EXEC and consumed by MEM/WB
  typedef struct packed {
    logic            wreg;
    logic            load;
    logic            store;
    logic            jmp;
    logic [XLEN-1:0] target;
  } exec_lat_t;

endpackage

// File: rtl/cpu_sequencer_if.sv
// Instruction- and data-memory request/ready handshake bundle.
interface cpu_sequencer_if;
  import cpu_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;
  logic [XLEN-1:0] imem_rdata;
  logic            dmem_req;
  logic            dmem_we;
  logic            dmem_ready;

  modport master (
    output imem_req, imem_addr, dmem_req, dmem_we,
    input  imem_ready, imem_rdata, dmem_ready
  );

  modport slave (
    input  imem_req, imem_addr, dmem_req, dmem_we,
    output imem_ready, imem_rdata, dmem_ready
  );

endinterface

// File: rtl/cpu_sequencer_wait_timer.sv
// Memory wait budget: counts stalled cycles and flags the last one allowed.
module wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(MEM_TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             expired_q, expired_d;

  // expired marks a cycle that already holds MEM_TIMEOUT-1 stalls behind it
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    expired_d = (cnt_d == LAST_WAIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      expired_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      expired_q <= expired_d;
    end
  end

  assign expired = expired_q;

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer: owns PC and IR and steps each instruction
// through fetch, decode, execute, optional memory access and writeback.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cpu_sequencer_if.master      bus,
  output logic [XLEN-1:0]      pc,
  output logic [XLEN-1:0]      ins,
  input  logic                 dec_valid,
  input  logic                 dec_wreg,
  input  logic                 dec_is_jmp,
  input  logic [XLEN-1:0]      dec_jmp_addr,
  input  logic                 dec_is_load,
  input  logic                 dec_is_store,
  output logic                 reg_we,
  output logic                 wb_sel,
  output logic                 illegal,
  output logic                 bus_err,
  output logic [ST_W-1:0]      state
);

  logic [ST_W-1:0] state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] ins_q, ins_d;
  exec_lat_t       lat_q, lat_d;
  logic            illegal_q, illegal_d;
  logic            bus_err_q, bus_err_d;
  logic            imem_req_q, imem_req_d;
  logic            dmem_req_q, dmem_req_d;
  logic            dmem_we_q, dmem_we_d;
  logic            reg_we_q, reg_we_d;
  logic            wb_sel_q, wb_sel_d;
  logic            tmr_clr, tmr_en, tmr_expired;

  // Ready only counts while the matching request is actually up
  logic imem_ack, dmem_ack;
  assign imem_ack = imem_req_q & bus.imem_ready;
  assign dmem_ack = dmem_req_q & bus.dmem_ready;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ins_d     = ins_q;
    lat_d     = lat_q;
    illegal_d = illegal_q;
    bus_err_d = bus_err_q;

    case (state_q)
      ST_RST:    state_d = ST_FETCH;
      ST_FETCH: begin
        if (imem_ack) begin
          ins_d   = bus.imem_rdata;
          state_d = ST_DECODE;
        end else if (tmr_expired) begin
          bus_err_d = 1'b1;
          state_d   = ST_HALT;
        end
      end
      ST_DECODE: state_d = ST_EXEC;
      ST_EXEC: begin
        lat_d.wreg   = dec_wreg;
        lat_d.load   = dec_is_load;
        lat_d.store  = dec_is_store;
        lat_d.jmp    = dec_is_jmp;
        lat_d.target = dec_jmp_addr;
        if (!dec_valid || (dec_is_jmp && (dec_jmp_addr[1:0] != 2'b00))) begin
          illegal_d = 1'b1;
          state_d   = ST_HALT;
        end else if (dec_is_load || dec_is_store) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        if (dmem_ack) begin
          state_d = ST_WB;
        end else if (tmr_expired) begin
          bus_err_d = 1'b1;
          state_d   = ST_HALT;
        end
      end
      ST_WB: begin
        pc_d    = lat_q.jmp ? lat_q.target : (pc_q + XLEN'(4));
        state_d = ST_FETCH;
      end
      ST_HALT:   state_d = ST_HALT;
      default:   state_d = ST_RST;
    endcase

    // Strobes are registered copies of the next state so they track state_q
    imem_req_d = (state_d == ST_FETCH);
    dmem_req_d = (state_d == ST_MEM);
    dmem_we_d  = (state_d == ST_MEM) & lat_d.store;
    reg_we_d   = (state_d == ST_WB) & lat_d.wreg;
    wb_sel_d   = (state_d == ST_WB) & lat_d.load;
  end

  assign tmr_clr = (state_d != state_q);
  assign tmr_en  = (imem_req_q & ~bus.imem_ready) | (dmem_req_q & ~bus.dmem_ready);

  wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .expired (tmr_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RST;
      pc_q       <= RESET_PC;
      ins_q      <= NOP_INS;
      lat_q      <= '0;
      illegal_q  <= 1'b0;
      bus_err_q  <= 1'b0;
      imem_req_q <= 1'b0;
      dmem_req_q <= 1'b0;
      dmem_we_q  <= 1'b0;
      reg_we_q   <= 1'b0;
      wb_sel_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ins_q      <= ins_d;
      lat_q      <= lat_d;
      illegal_q  <= illegal_d;
      bus_err_q  <= bus_err_d;
      imem_req_q <= imem_req_d;
      dmem_req_q <= dmem_req_d;
      dmem_we_q  <= dmem_we_d;
      reg_we_q   <= reg_we_d;
      wb_sel_q   <= wb_sel_d;
    end
  end

  assign bus.imem_req  = imem_req_q;
  assign bus.imem_addr = pc_q;
  assign bus.dmem_req  = dmem_req_q;
  assign bus.dmem_we   = dmem_we_q;
  assign pc            = pc_q;
  assign ins           = ins_q;
  assign reg_we        = reg_we_q;
  assign wb_sel        = wb_sel_q;
  assign illegal       = illegal_q;
  assign bus_err       = bus_err_q;
  assign state         = state_q;

endmodule
